// File: rtl/pong_sfx_if.sv
// Signal bundle between the collision controller / bench (master)
// and the Pong sound-effect generator (slave).
interface pong_sfx_if;
  logic       en;
  logic       pad_col;
  logic       wall_col;
  logic       lossA;
  logic       lossB;
  logic       spk;
  logic       busy;
  logic [1:0] snd_id;

  modport master (
    output en, pad_col, wall_col, lossA, lossB,
    input  spk, busy, snd_id
  );

  modport slave (
    input  en, pad_col, wall_col, lossA, lossB,
    output spk, busy, snd_id
  );
endinterface

// File: rtl/pong_sfx.sv
// Pong sound-effect generator: prioritised paddle blip, wall tone and
// four-note game-over jingle on a 1-bit square-wave speaker line.
module pong_sfx #(
  parameter int unsigned TICK_DIV  = 25000,
  parameter int unsigned PAD_HALF  = 20833,
  parameter int unsigned PAD_LEN   = 40,
  parameter int unsigned WALL_HALF = 50000,
  parameter int unsigned WALL_LEN  = 150,
  parameter int unsigned OVER_HI   = 25000,
  parameter int unsigned OVER_LO   = 37500,
  parameter int unsigned OVER_LEN  = 200
) (
  input  logic       clk,
  input  logic       rst_n,
  pong_sfx_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PAD  = 2'd1,
    S_WALL = 2'd2,
    S_OVER = 2'd3
  } state_t;

  localparam logic [15:0] TICK_LAST = 16'(TICK_DIV - 1);
  localparam logic [15:0] PAD_H     = 16'(PAD_HALF);
  localparam logic [15:0] WALL_H    = 16'(WALL_HALF);
  localparam logic [15:0] OVER_HI_H = 16'(OVER_HI);
  localparam logic [15:0] OVER_LO_H = 16'(OVER_LO);
  localparam logic [9:0]  PAD_LAST  = 10'(PAD_LEN - 1);
  localparam logic [9:0]  WALL_LAST = 10'(WALL_LEN - 1);
  localparam logic [9:0]  OVER_LAST = 10'(OVER_LEN - 1);

  function automatic logic [15:0] half_of(input state_t st, input logic [1:0] note);
    logic [15:0] h;
    case (st)
      S_PAD:   h = PAD_H;
      S_WALL:  h = WALL_H;
      S_OVER:  h = note[0] ? OVER_LO_H : OVER_HI_H;
      default: h = 16'd0;
    endcase
    return h;
  endfunction

  function automatic logic [9:0] len_last_of(input state_t st);
    logic [9:0] l;
    case (st)
      S_PAD:   l = PAD_LAST;
      S_WALL:  l = WALL_LAST;
      S_OVER:  l = OVER_LAST;
      default: l = 10'd0;
    endcase
    return l;
  endfunction

  logic        pad_q;
  logic        wall_q;
  logic        loss_q;
  logic        loss_s;
  logic        pad_ev_s;
  logic        wall_ev_s;
  logic        loss_ev_s;

  state_t      state_r;
  state_t      state_nx_s;
  state_t      start_st_s;
  logic        start_s;
  logic        note_adv_s;

  logic [15:0] hc_r;
  logic [15:0] ps_r;
  logic [9:0]  dc_r;
  logic [1:0]  note_r;
  logic [15:0] half_r;
  logic        spk_r;

  logic [15:0] hc_nx_s;
  logic [15:0] ps_nx_s;
  logic [9:0]  dc_nx_s;
  logic [1:0]  note_nx_s;
  logic [15:0] half_nx_s;
  logic        spk_nx_s;

  logic        tick_s;
  logic        eff_end_s;
  logic        hc_last_s;

  assign loss_s    = bus.lossA | bus.lossB;
  assign pad_ev_s  = bus.pad_col  & ~pad_q;
  assign wall_ev_s = bus.wall_col & ~wall_q;
  assign loss_ev_s = loss_s       & ~loss_q;

  assign tick_s    = (ps_r == TICK_LAST);
  assign eff_end_s = tick_s && (dc_r == len_last_of(state_r));
  assign hc_last_s = (hc_r == (half_r - 16'd1));

  // Edge-detect history; tracks the inputs even while muted so that
  // levels seen during mute never fire later.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pad_q  <= 1'b0;
      wall_q <= 1'b0;
      loss_q <= 1'b0;
    end else begin
      pad_q  <= bus.pad_col;
      wall_q <= bus.wall_col;
      loss_q <= loss_s;
    end
  end

  // State and tone/duration datapath registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= S_IDLE;
      hc_r    <= 16'd0;
      ps_r    <= 16'd0;
      dc_r    <= 10'd0;
      note_r  <= 2'd0;
      half_r  <= 16'd0;
      spk_r   <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      hc_r    <= hc_nx_s;
      ps_r    <= ps_nx_s;
      dc_r    <= dc_nx_s;
      note_r  <= note_nx_s;
      half_r  <= half_nx_s;
      spk_r   <= spk_nx_s;
    end
  end

  // Next-state: event arbitration (OVER > WALL > PAD, equal restarts),
  // otherwise effect sequencing.
  always_comb begin
    state_nx_s = state_r;
    start_s    = 1'b0;
    start_st_s = S_IDLE;
    note_adv_s = 1'b0;
    if (!bus.en) begin
      state_nx_s = S_IDLE;
    end else if (loss_ev_s && (state_r != S_OVER)) begin
      start_s    = 1'b1;
      start_st_s = S_OVER;
      state_nx_s = S_OVER;
    end else if (wall_ev_s && (state_r != S_OVER)) begin
      start_s    = 1'b1;
      start_st_s = S_WALL;
      state_nx_s = S_WALL;
    end else if (pad_ev_s && ((state_r == S_IDLE) || (state_r == S_PAD))) begin
      start_s    = 1'b1;
      start_st_s = S_PAD;
      state_nx_s = S_PAD;
    end else begin
      case (state_r)
        S_IDLE: state_nx_s = S_IDLE;
        S_PAD, S_WALL: begin
          if (eff_end_s) begin
            state_nx_s = S_IDLE;
          end else begin
            state_nx_s = state_r;
          end
        end
        S_OVER: begin
          if (eff_end_s && (note_r == 2'd3)) begin
            state_nx_s = S_IDLE;
          end else if (eff_end_s) begin
            note_adv_s = 1'b1;
          end else begin
            state_nx_s = S_OVER;
          end
        end
        default: state_nx_s = S_IDLE;
      endcase
    end
  end

  // Datapath next values: clear on start/note change/idle, otherwise run.
  always_comb begin
    hc_nx_s   = hc_r;
    ps_nx_s   = ps_r;
    dc_nx_s   = dc_r;
    note_nx_s = note_r;
    half_nx_s = half_r;
    spk_nx_s  = spk_r;
    if (start_s) begin
      hc_nx_s   = 16'd0;
      ps_nx_s   = 16'd0;
      dc_nx_s   = 10'd0;
      note_nx_s = 2'd0;
      half_nx_s = half_of(start_st_s, 2'd0);
      spk_nx_s  = 1'b0;
    end else if (state_nx_s == S_IDLE) begin
      hc_nx_s   = 16'd0;
      ps_nx_s   = 16'd0;
      dc_nx_s   = 10'd0;
      note_nx_s = 2'd0;
      half_nx_s = 16'd0;
      spk_nx_s  = 1'b0;
    end else if (note_adv_s) begin
      hc_nx_s   = 16'd0;
      ps_nx_s   = 16'd0;
      dc_nx_s   = 10'd0;
      note_nx_s = note_r + 2'd1;
      half_nx_s = half_of(S_OVER, note_r + 2'd1);
      spk_nx_s  = 1'b0;
    end else begin
      if (hc_last_s) begin
        hc_nx_s  = 16'd0;
        spk_nx_s = ~spk_r;
      end else begin
        hc_nx_s  = hc_r + 16'd1;
        spk_nx_s = spk_r;
      end
      if (tick_s) begin
        ps_nx_s = 16'd0;
        dc_nx_s = dc_r + 10'd1;
      end else begin
        ps_nx_s = ps_r + 16'd1;
        dc_nx_s = dc_r;
      end
    end
  end

  // Outputs are taken straight from registers.
  always_comb begin
    bus.spk    = spk_r;
    bus.busy   = (state_r != S_IDLE);
    bus.snd_id = state_r;
  end

endmodule

// File: tb/tb_pong_sfx.sv
// Directed bench for pong_sfx: six scenarios, each checked cycle by cycle
// against hand-derived windows for busy, snd_id and spk.
module tb_pong_sfx;

  logic clk;
  logic rst_n;
  int   cyc;
  int   n_checks;
  int   n_errors;

  pong_sfx_if sfx ();

  pong_sfx #(
    .TICK_DIV (4),
    .PAD_HALF (3),
    .PAD_LEN  (5),
    .WALL_HALF(5),
    .WALL_LEN (6),
    .OVER_HI  (2),
    .OVER_LO  (4),
    .OVER_LEN (3)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (sfx.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", tag, cyc, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic int sq(input int c, input int s, input int h);
    return ((c - s) / h) % 2;
  endfunction

  task automatic do_reset();
    rst_n        = 1'b0;
    sfx.en       = 1'b1;
    sfx.pad_col  = 1'b0;
    sfx.wall_col = 1'b0;
    sfx.lossA    = 1'b0;
    sfx.lossB    = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    cyc   = 0;
    check_val("rst_busy", int'(sfx.busy), 0);
    check_val("rst_id", int'(sfx.snd_id), 0);
    check_val("rst_spk", int'(sfx.spk), 0);
  endtask

  task automatic run_test(input int t, input int n);
    int e_id;
    int e_spk;
    do_reset();
    for (int c = 1; c <= n; c++) begin
      step();
      e_id  = 0;
      e_spk = 0;
      case (t)
        1: begin
          sfx.pad_col = (c >= 10 && c <= 59);
          if (c >= 11 && c <= 30) begin e_id = 1; e_spk = sq(c, 11, 3); end
        end
        2: begin
          sfx.pad_col  = (c >= 10 && c <= 12) || (c >= 20 && c <= 21);
          sfx.wall_col = (c >= 15 && c <= 17);
          if (c >= 11 && c <= 15) begin e_id = 1; e_spk = sq(c, 11, 3); end
          else if (c >= 16 && c <= 39) begin e_id = 2; e_spk = sq(c, 16, 5); end
        end
        3: begin
          sfx.lossB    = (c >= 10);
          sfx.wall_col = (c == 20 || c == 21);
          sfx.pad_col  = (c == 30 || c == 31);
          if (c >= 11 && c <= 58) begin
            e_id = 3;
            if (c < 23)      e_spk = sq(c, 11, 2);
            else if (c < 35) e_spk = sq(c, 23, 4);
            else if (c < 47) e_spk = sq(c, 35, 2);
            else             e_spk = sq(c, 47, 4);
          end
        end
        4: begin
          sfx.pad_col = (c == 10 || c == 14);
          if (c >= 11 && c <= 14) begin e_id = 1; e_spk = sq(c, 11, 3); end
          else if (c >= 15 && c <= 34) begin e_id = 1; e_spk = sq(c, 15, 3); end
        end
        5: begin
          sfx.wall_col = (c >= 10);
          sfx.en       = !(c >= 20 && c <= 24);
          sfx.pad_col  = (c >= 22);
          if (c >= 11 && c <= 20) begin e_id = 2; e_spk = sq(c, 11, 5); end
        end
        6: begin
          sfx.lossA = (c >= 10);
          rst_n     = !(c == 30);
          if (c >= 11 && c <= 30) begin
            e_id  = 3;
            e_spk = (c < 23) ? sq(c, 11, 2) : sq(c, 23, 4);
          end else if (c >= 32 && c <= 79) begin
            e_id = 3;
            if (c < 44)      e_spk = sq(c, 32, 2);
            else if (c < 56) e_spk = sq(c, 44, 4);
            else if (c < 68) e_spk = sq(c, 56, 2);
            else             e_spk = sq(c, 68, 4);
          end
        end
        default: begin
          e_id = 0;
        end
      endcase
      check_val($sformatf("t%0d_id", t), int'(sfx.snd_id), e_id);
      check_val($sformatf("t%0d_busy", t), int'(sfx.busy), (e_id != 0) ? 1 : 0);
      check_val($sformatf("t%0d_spk", t), int'(sfx.spk), e_spk);
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    cyc      = 0;
    run_test(1, 65);
    run_test(2, 45);
    run_test(3, 65);
    run_test(4, 40);
    run_test(5, 40);
    run_test(6, 85);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pong_sfx.md
# pong_sfx

Sound-effect generator for Pong that sits directly downstream of the collision controller. It consumes the controller's `pad_col`, `wall_col`, `lossA` and `lossB` outputs. It drives a 1-bit square-wave speaker line with three prioritised effects: paddle blip, wall/score tone, and a four-note game-over jingle. It is purely sequential, in the single `clk` domain, and shares the controller's clock.

## Interface
Parameters:
- `TICK_DIV`, 25000: clk cycles per duration tick (1 ms at 25 MHz); 1..65535.
- `PAD_HALF`, 20833: half-period of the paddle tone, in clk cycles; 2..65535.
- `PAD_LEN`, 40: paddle effect length, in ticks; 1..1023.
- `WALL_HALF`, 50000: half-period of the wall tone, in clk cycles; 2..65535.
- `WALL_LEN`, 150: wall effect length, in ticks; 1..1023.
- `OVER_HI`, 25000: half-period of jingle notes 0 and 2; 2..65535.
- `OVER_LO`, 37500: half-period of jingle notes 1 and 3; 2..65535.
- `OVER_LEN`, 200: length of each jingle note, in ticks; 1..1023.

Ports:
- `clk`, in, 1: system clock.
- `rst_n`, in, 1: reset, synchronous, active-low; clock `clk`.
- `en`, in, 1: audio enable; 0 = mute and idle.
- `pad_col`, in, 1: paddle-collision flag (level; may stay high for many clk cycles).
- `wall_col`, in, 1: wall-collision/score flag (level).
- `lossA`, in, 1: player A lost (level).
- `lossB`, in, 1: player B lost (level).
- `spk`, out, 1: square-wave speaker output.
- `busy`, out, 1: an effect is playing.
- `snd_id`, out, 2: current effect; 0 = none, 1 = pad, 2 = wall, 3 = game over.

## Operation
- Edge detection: registers `pad_q`, `wall_q` and `loss_q` (where loss = `lossA`|`lossB`) update every cycle, including when `en` = 0.
  - Events are the rising edges, e.g. `pad_ev` = `pad_col` & ~`pad_q`.
  - All `*_q` registers reset to 0, so a level already high when reset is released counts as an edge on the first cycle.
- State machine has four states: IDLE, PAD, WALL, OVER.
  - `snd_id` = 0/1/2/3 respectively.
  - `busy` = (state != IDLE).
- Priority is OVER > WALL > PAD.
  - An event starts its effect if the current state is IDLE or has priority ≤ the event's priority. Equal priority restarts the effect.
  - Lower-priority events are dropped and never queued.
  - Once in OVER, every event is ignored, including a new loss edge.
  - Simultaneous events: the highest-priority one wins.
- Effect start: set the half-period counter to 0, the tick prescaler to 0, the duration counter to 0, and `spk` to 0. Load the note's half-period.
- Tone generation:
  - The half-period counter counts 0..HALF-1.
  - At HALF-1 it toggles `spk` and wraps to 0.
- Duration:
  - The prescaler counts 0..TICK_DIV-1 and emits a tick on TICK_DIV-1.
  - The duration counter increments on each tick.
  - On the tick where it equals LEN-1, the effect ends.
- End of PAD or WALL: go to IDLE with `spk` = 0.
- OVER sequence:
  - Plays note index 0..3 with half-periods HI, LO, HI, LO, each OVER_LEN ticks.
  - At each note end: increment the note index, reload the half-period, and clear the half-period counter, prescaler and `spk`.
  - After note 3: go to IDLE.
- `en` = 0: the state is forced to IDLE, `spk` = 0, and events are discarded.
- Reset: all outputs 0 and the state is IDLE, regardless of activity. An effect in progress is abandoned.

## Timing
- An event edge present in cycle n makes `busy`/`snd_id` valid in cycle n+1.
- First `spk` toggle (0→1): `spk` is high from cycle n+1+HALF.
- A single effect keeps `busy` high for exactly LEN×TICK_DIV cycles.
  - `busy` is 0 from cycle n+1+LEN×TICK_DIV, unless the effect is restarted or preempted.
- The full jingle lasts exactly 4×OVER_LEN×TICK_DIV cycles.
- Note changes occur with no gap and no extra cycle.
- A restart or preemption in cycle m resets all counters, so the new effect is timed from m+1.
- Counter widths:
  - Half-period counter: 16 bits.
  - Prescaler: 16 bits.
  - Duration counter: 10 bits.
  - Note index: 2 bits.
  - There is no overflow within the legal parameter ranges.

## Test plan
Bench parameters: TICK_DIV=4, PAD_HALF=3, PAD_LEN=5, WALL_HALF=5, WALL_LEN=6, OVER_HI=2, OVER_LO=4, OVER_LEN=3, `en`=1.
- `pad_col` held high for 50 cycles from cycle 10 → exactly one effect.
  - `snd_id`=1 and `busy`=1 in cycles 11..30; IDLE at 31.
  - `spk` toggles every 3 cycles, first high at 14.
- Paddle effect started at cycle 10, `wall_col` edge at 15 → `snd_id`=2 from 16.
  - `busy` ends at 40 (16+24).
  - A `pad_col` edge at 20 is ignored.
- `lossB` rises at cycle 10 → `snd_id`=3 for cycles 11..58.
  - Half-period 2 in 11..22, 4 in 23..34, 2 in 35..46, 4 in 47..58.
  - `wall_col`/`pad_col` edges during this window are ignored.
- Paddle edge at 10 and again at 14 → restart; `busy` ends at 35.
- `en` dropped mid-wall-effect → next cycle IDLE and `spk`=0.
  - An edge while `en`=0 does not fire later when `en` returns high.
- `rst_n` low for 1 cycle mid-jingle → all outputs 0 next cycle.
  - `lossA` still high at release → jingle restarts.
